// File: rtl/mc_eject_reinject_pkg.sv
// Shared dstList geometry and helpers for the multicast ejection/re-injection path.
package mc_eject_reinject_pkg;

    localparam int DST_LIST_WIDTH = 16;
    localparam int NUM_PORT       = 5;

    localparam logic [DST_LIST_WIDTH-1:0] N_MASK = 16'h0001;
    localparam logic [DST_LIST_WIDTH-1:0] E_MASK = 16'h0002;
    localparam logic [DST_LIST_WIDTH-1:0] S_MASK = 16'h0004;
    localparam logic [DST_LIST_WIDTH-1:0] W_MASK = 16'h0008;
    localparam logic [DST_LIST_WIDTH-1:0] L_MASK = 16'h0010;

    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == STAT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mc_flit_fifo.sv
// Synchronous FIFO with registered head; storage is not reset, only pointers and count.
module mc_flit_fifo
    import mc_eject_reinject_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A full FIFO still accepts a push when the same cycle pops.
    assign do_push = push && ((count != FULL) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mc_eject_reinject.sv
// Multicast fork on the local ejection port: local copy to the PE, residual dstList re-injected.
module mc_eject_reinject
    import mc_eject_reinject_pkg::*;
#(
    parameter int FLIT_WIDTH = 128,
    parameter int DLW        = DST_LIST_WIDTH,
    parameter int PE_DEPTH   = 4,
    parameter int RI_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ej_valid,
    input  logic [FLIT_WIDTH-1:0] ej_flit,
    input  logic [DLW-1:0]        ej_dst,
    output logic                  ej_ready,
    output logic                  pe_valid,
    output logic [FLIT_WIDTH-1:0] pe_flit,
    input  logic                  pe_ready,
    output logic                  ri_valid,
    output logic [FLIT_WIDTH-1:0] ri_flit,
    output logic [DLW-1:0]        ri_dst,
    input  logic                  ri_grant,
    output logic [15:0]           stat_reinj,
    output logic                  err_drop
);

    localparam int PAW = $clog2(PE_DEPTH);
    localparam int RAW = $clog2(RI_DEPTH);
    localparam logic [PAW:0] PE_LIMIT = (PAW+1)'(PE_DEPTH - 2);
    localparam logic [RAW:0] RI_LIMIT = (RAW+1)'(RI_DEPTH - 2);
    localparam logic [DLW-1:0] LOC = DLW'(L_MASK);

    logic                      accept;
    logic                      loc;
    logic [DLW-1:0]            res;
    logic                      pe_push;
    logic                      ri_push;
    logic                      pe_pop;
    logic                      ri_pop;
    logic [PAW:0]              pe_count;
    logic [RAW:0]              ri_count;
    logic [PAW:0]              pe_count_nxt;
    logic [RAW:0]              ri_count_nxt;
    logic [FLIT_WIDTH+DLW-1:0] ri_head;

    assign accept  = ej_valid && ej_ready;
    assign loc     = |(ej_dst & LOC);
    assign res     = ej_dst & ~LOC;
    assign pe_push = accept && loc;
    assign ri_push = accept && (res != '0);

    assign pe_valid = (pe_count != '0);
    assign ri_valid = (ri_count != '0);
    assign pe_pop   = pe_valid && pe_ready;
    assign ri_pop   = ri_valid && ri_grant;

    assign ri_flit = ri_head[FLIT_WIDTH+DLW-1:DLW];
    assign ri_dst  = ri_valid ? ri_head[DLW-1:0] : '0;

    mc_flit_fifo #(.WIDTH(FLIT_WIDTH), .DEPTH(PE_DEPTH)) u_pe_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pe_push),
        .push_data (ej_flit),
        .pop       (pe_pop),
        .head      (pe_flit),
        .count     (pe_count)
    );

    mc_flit_fifo #(.WIDTH(FLIT_WIDTH + DLW), .DEPTH(RI_DEPTH)) u_ri_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ri_push),
        .push_data ({ej_flit, res}),
        .pop       (ri_pop),
        .head      (ri_head),
        .count     (ri_count)
    );

    // Occupancy the FIFOs will hold after this edge; ej_ready is registered from it
    // so the router sees the stop one cycle before it would eject into the last slot.
    assign pe_count_nxt = pe_count + (PAW+1)'(pe_push) - (PAW+1)'(pe_pop);
    assign ri_count_nxt = ri_count + (RAW+1)'(ri_push) - (RAW+1)'(ri_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ej_ready   <= 1'b1;
            stat_reinj <= '0;
            err_drop   <= 1'b0;
        end else begin
            ej_ready <= (pe_count_nxt <= PE_LIMIT) && (ri_count_nxt <= RI_LIMIT);
            if (ri_pop)                 stat_reinj <= sat_inc16(stat_reinj);
            if (ej_valid && !ej_ready)  err_drop   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_eject_reinject.sv
// Randomized and directed bench for mc_eject_reinject against a queue-based reference model.
module tb_mc_eject_reinject;
    import mc_eject_reinject_pkg::*;

    localparam int FW  = 128;
    localparam int DW  = DST_LIST_WIDTH;
    localparam int PED = 4;
    localparam int RID = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ej_valid = 1'b0;
    logic [FW-1:0] ej_flit = '0;
    logic [DW-1:0] ej_dst = '0;
    logic          ej_ready;
    logic          pe_valid;
    logic [FW-1:0] pe_flit;
    logic          pe_ready = 1'b0;
    logic          ri_valid;
    logic [FW-1:0] ri_flit;
    logic [DW-1:0] ri_dst;
    logic          ri_grant = 1'b0;
    logic [15:0]   stat_reinj;
    logic          err_drop;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [FW-1:0]    pe_q[$];
    logic [FW+DW-1:0] ri_q[$];
    logic             m_ready;
    int               m_stat;
    logic             m_err;

    always #5 clk = ~clk;

    mc_eject_reinject #(.FLIT_WIDTH(FW), .DLW(DW), .PE_DEPTH(PED), .RI_DEPTH(RID)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ej_valid   (ej_valid),
        .ej_flit    (ej_flit),
        .ej_dst     (ej_dst),
        .ej_ready   (ej_ready),
        .pe_valid   (pe_valid),
        .pe_flit    (pe_flit),
        .pe_ready   (pe_ready),
        .ri_valid   (ri_valid),
        .ri_flit    (ri_flit),
        .ri_dst     (ri_dst),
        .ri_grant   (ri_grant),
        .stat_reinj (stat_reinj),
        .err_drop   (err_drop)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] rnd_flit();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        pe_q.delete();
        ri_q.delete();
        m_ready = 1'b1;
        m_stat  = 0;
        m_err   = 1'b0;
    endtask

    // One clock of the behavioural rules, applied to the inputs seen at the edge.
    task automatic model_edge();
        logic [DW-1:0] res;
        res = ej_dst & ~L_MASK;
        if (pe_q.size() != 0 && pe_ready) void'(pe_q.pop_front());
        if (ri_q.size() != 0 && ri_grant) begin
            void'(ri_q.pop_front());
            if (m_stat < 65535) m_stat++;
        end
        if (ej_valid && !m_ready) m_err = 1'b1;
        if (ej_valid && m_ready) begin
            if ((ej_dst & L_MASK) != '0) pe_q.push_back(ej_flit);
            if (res != '0) ri_q.push_back({ej_flit, res});
        end
        m_ready = (pe_q.size() <= PED - 2) && (ri_q.size() <= RID - 2);
    endtask

    task automatic check_outputs();
        check("pe_valid", pe_valid, pe_q.size() != 0);
        if (pe_q.size() != 0) check("pe_flit", pe_flit, pe_q[0]);
        check("ri_valid", ri_valid, ri_q.size() != 0);
        if (ri_q.size() != 0) begin
            check("ri_flit", ri_flit, ri_q[0][FW+DW-1:DW]);
            check("ri_dst", ri_dst, ri_q[0][DW-1:0]);
        end else begin
            check("ri_dst_idle", ri_dst, '0);
        end
        check("ej_ready", ej_ready, m_ready);
        check("stat_reinj", stat_reinj, m_stat);
        check("err_drop", err_drop, m_err);
    endtask

    task automatic step(input logic v, input logic [FW-1:0] f, input logic [DW-1:0] d,
                        input logic prdy, input logic gnt);
        ej_valid = v;
        ej_flit  = f;
        ej_dst   = d;
        pe_ready = prdy;
        ri_grant = gnt;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic prdy, input logic gnt);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, prdy, gnt);
    endtask

    initial begin
        logic [FW-1:0] fa;
        logic [FW-1:0] fb;
        logic [DW-1:0] d;
        model_reset();

        // reset values
        #12;
        check("rst_pe_valid", pe_valid, 1'b0);
        check("rst_ri_valid", ri_valid, 1'b0);
        check("rst_ri_dst", ri_dst, '0);
        check("rst_stat", stat_reinj, 16'd0);
        check("rst_err", err_drop, 1'b0);
        check("rst_ej_ready", ej_ready, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // local-only delivery
        fa = rnd_flit();
        step(1'b1, fa, L_MASK, 1'b1, 1'b0);
        check("t1_pe_flit", pe_flit, fa);
        check("t1_ri_valid", ri_valid, 1'b0);
        idle(2, 1'b1, 1'b0);

        // local fork, grant held off two cycles
        fb = rnd_flit();
        step(1'b1, fb, L_MASK | E_MASK, 1'b1, 1'b0);
        check("t2_pe_flit", pe_flit, fb);
        check("t2_ri_dst", ri_dst, E_MASK);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("t2_ri_dst_hold", ri_dst, E_MASK);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        check("t2_stat", stat_reinj, 16'd1);

        // continuous local ejection, pointers wrap
        for (int i = 0; i < 12; i++) step(1'b1, rnd_flit(), L_MASK, 1'b1, 1'b0);
        check("t4_ej_ready", ej_ready, 1'b1);
        idle(2, 1'b1, 1'b0);

        // PE backpressure, then a protocol violation
        for (int i = 0; i < 3; i++) step(1'b1, rnd_flit(), L_MASK, 1'b0, 1'b0);
        check("t3_ej_ready", ej_ready, 1'b0);
        step(1'b1, rnd_flit(), L_MASK, 1'b0, 1'b0);
        check("t3_err", err_drop, 1'b1);
        idle(5, 1'b1, 1'b0);

        // reset with both FIFOs holding two flits
        for (int i = 0; i < 2; i++) step(1'b1, rnd_flit(), L_MASK | S_MASK, 1'b0, 1'b0);
        check("t5_pre_ri_valid", ri_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t5_pe_valid", pe_valid, 1'b0);
        check("t5_ri_valid", ri_valid, 1'b0);
        check("t5_stat", stat_reinj, 16'd0);
        check("t5_err", err_drop, 1'b0);
        idle(2, 1'b1, 1'b1);
        rst_n = 1'b1;
        idle(3, 1'b1, 1'b1);

        // null dstList
        step(1'b1, rnd_flit(), '0, 1'b0, 1'b0);
        check("t6_pe_valid", pe_valid, 1'b0);
        check("t6_ri_valid", ri_valid, 1'b0);
        check("t6_err", err_drop, 1'b0);

        // randomized traffic within the ready protocol
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: d = '0;
                1: d = L_MASK;
                2: d = DW'($urandom) | L_MASK;
                default: d = DW'($urandom) & ~L_MASK;
            endcase
            step(m_ready && ($urandom_range(0, 3) != 0), rnd_flit(), d,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1);
        end
        idle(10, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
